// File: rtl/ika2151_pkg.sv
// Shared state encoding, timing defaults and chip-select decode for the IKA2151 bus writer.
package ika2151_pkg;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_POLL_SU  = 4'd1,
        ST_POLL_ST  = 4'd2,
        ST_POLL_GAP = 4'd3,
        ST_A_SU     = 4'd4,
        ST_A_ST     = 4'd5,
        ST_A_GAP    = 4'd6,
        ST_D_SU     = 4'd7,
        ST_D_ST     = 4'd8,
        ST_D_GAP    = 4'd9
    } bw_state_t;

    localparam int DEF_FIFO_DEPTH = 16;
    localparam int DEF_SETUP_CYC  = 15;
    localparam int DEF_STROBE_CYC = 20;
    localparam int DEF_GAP_CYC    = 15;
    localparam int CNT_W          = 16;

    // Active-low one-hot select; an index at or beyond num_chips leaves every line high.
    function automatic logic [7:0] cs_decode(input logic [2:0] chip, input int num_chips);
        logic [7:0] mask;
        mask = 8'hFF;
        for (int i = 0; i < 8; i++) begin
            if ((i < num_chips) && (chip == 3'(i))) begin
                mask[i] = 1'b0;
            end
        end
        return mask;
    endfunction

endpackage

// File: rtl/ika2151_bw_fifo.sv
// Write-request queue: registered pointers/level, combinational head read, push refused when full.
module ika2151_bw_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 19,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty,
    output logic [AW:0]      o_level
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [AW:0]      r_level;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_level == (AW+1)'(DEPTH));
    assign o_empty = (r_level == '0);
    assign o_level = r_level;
    assign o_rdata = r_mem[r_rptr];
    assign w_push  = i_push & ~o_full;
    assign w_pop   = i_pop & ~o_empty;

    // Storage array; contents need no reset since the level gates every read.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= i_wdata;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + AW'(1);
            if (w_pop)  r_rptr <= r_rptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + (AW+1)'(1);
                2'b01:   r_level <= r_level - (AW+1)'(1);
                default: r_level <= r_level;
            endcase
        end
    end

endmodule

// File: rtl/ika2151_bus_writer.sv
// Replays queued (chip, addr, data) writes as two-phase CS_n/WR_n/A0/D bus cycles, optionally
// polling the BUSY flag first. Every bus output comes straight from a register.
module ika2151_bus_writer
    import ika2151_pkg::*;
#(
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter int NUM_CHIPS  = 1,
    parameter int SETUP_CYC  = DEF_SETUP_CYC,
    parameter int STROBE_CYC = DEF_STROBE_CYC,
    parameter int GAP_CYC    = DEF_GAP_CYC,
    parameter int BUSY_POLL  = 0,
    localparam int CHIP_W    = (NUM_CHIPS > 1) ? $clog2(NUM_CHIPS) : 1,
    localparam int LVL_W     = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                 i_EMUCLK,
    input  logic                 i_RST,
    input  logic                 i_REQ_VALID,
    output logic                 o_REQ_READY,
    input  logic [CHIP_W-1:0]    i_REQ_CHIP,
    input  logic [7:0]           i_REQ_ADDR,
    input  logic [7:0]           i_REQ_DATA,
    output logic [NUM_CHIPS-1:0] o_CS_n,
    output logic                 o_WR_n,
    output logic                 o_RD_n,
    output logic                 o_A0,
    output logic [7:0]           o_D,
    input  logic [7:0]           i_D,
    output logic                 o_IDLE,
    output logic [LVL_W-1:0]     o_LEVEL
);

    localparam int ENT_W = CHIP_W + 16;
    localparam logic [CNT_W-1:0] SU_LAST  = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] ST_LAST  = CNT_W'(STROBE_CYC - 1);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYC - 1);
    localparam logic [NUM_CHIPS-1:0] CS_OFF = {NUM_CHIPS{1'b1}};

    logic              w_pop;
    logic              w_full;
    logic              w_empty;
    logic [ENT_W-1:0]  w_head;
    logic [CHIP_W-1:0] w_head_chip;
    logic [7:0]        w_head_addr;
    logic [7:0]        w_head_data;
    logic [7:0]        w_cs_head;
    logic [7:0]        w_cs_work;
    logic              w_unused_d;

    bw_state_t         r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [CHIP_W-1:0] r_chip;
    logic [7:0]        r_addr;
    logic [7:0]        r_data;
    logic              r_busy;
    logic [NUM_CHIPS-1:0] r_cs_n;
    logic              r_wr_n;
    logic              r_rd_n;
    logic              r_a0;
    logic [7:0]        r_d;

    ika2151_bw_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(ENT_W)) u_fifo (
        .i_clk   (i_EMUCLK),
        .i_rst   (i_RST),
        .i_push  (i_REQ_VALID),
        .i_wdata ({i_REQ_CHIP, i_REQ_ADDR, i_REQ_DATA}),
        .i_pop   (w_pop),
        .o_rdata (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_level (o_LEVEL)
    );

    assign w_pop = (r_state == ST_IDLE) && !w_empty;
    assign {w_head_chip, w_head_addr, w_head_data} = w_head;
    assign w_cs_head  = cs_decode(3'(w_head_chip), NUM_CHIPS);
    assign w_cs_work  = cs_decode(3'(r_chip), NUM_CHIPS);
    assign w_unused_d = ^i_D[6:0];

    assign o_REQ_READY = ~w_full;
    assign o_IDLE      = (r_state == ST_IDLE) && w_empty;
    assign o_CS_n      = r_cs_n;
    assign o_WR_n      = r_wr_n;
    assign o_RD_n      = r_rd_n;
    assign o_A0        = r_a0;
    assign o_D         = r_d;

    // Sequencer: outputs for a state are loaded on the edge that enters it; A0/D move only entering *_SU.
    always_ff @(posedge i_EMUCLK or posedge i_RST) begin
        if (i_RST) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_chip  <= '0;
            r_addr  <= 8'h00;
            r_data  <= 8'h00;
            r_busy  <= 1'b0;
            r_cs_n  <= CS_OFF;
            r_wr_n  <= 1'b1;
            r_rd_n  <= 1'b1;
            r_a0    <= 1'b0;
            r_d     <= 8'h00;
        end else if ((r_state != ST_IDLE) && (r_cnt != '0)) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (!w_empty) begin
                        r_chip <= w_head_chip;
                        r_addr <= w_head_addr;
                        r_data <= w_head_data;
                        r_cnt  <= SU_LAST;
                        r_cs_n <= w_cs_head[NUM_CHIPS-1:0];
                        if (BUSY_POLL != 0) begin
                            r_state <= ST_POLL_SU;
                            r_a0    <= 1'b1;
                        end else begin
                            r_state <= ST_A_SU;
                            r_a0    <= 1'b0;
                            r_d     <= w_head_addr;
                        end
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_POLL_SU: begin
                    r_state <= ST_POLL_ST;
                    r_cnt   <= ST_LAST;
                    r_rd_n  <= 1'b0;
                end
                ST_POLL_ST: begin
                    r_busy  <= i_D[7];
                    r_state <= ST_POLL_GAP;
                    r_cnt   <= GAP_LAST;
                    r_rd_n  <= 1'b1;
                    r_cs_n  <= CS_OFF;
                end
                ST_POLL_GAP: begin
                    r_cnt  <= SU_LAST;
                    r_cs_n <= w_cs_work[NUM_CHIPS-1:0];
                    if (r_busy) begin
                        r_state <= ST_POLL_SU;
                        r_a0    <= 1'b1;
                    end else begin
                        r_state <= ST_A_SU;
                        r_a0    <= 1'b0;
                        r_d     <= r_addr;
                    end
                end
                ST_A_SU: begin
                    r_state <= ST_A_ST;
                    r_cnt   <= ST_LAST;
                    r_wr_n  <= 1'b0;
                end
                ST_A_ST: begin
                    r_state <= ST_A_GAP;
                    r_cnt   <= GAP_LAST;
                    r_wr_n  <= 1'b1;
                    r_cs_n  <= CS_OFF;
                end
                ST_A_GAP: begin
                    r_state <= ST_D_SU;
                    r_cnt   <= SU_LAST;
                    r_cs_n  <= w_cs_work[NUM_CHIPS-1:0];
                    r_a0    <= 1'b1;
                    r_d     <= r_data;
                end
                ST_D_SU: begin
                    r_state <= ST_D_ST;
                    r_cnt   <= ST_LAST;
                    r_wr_n  <= 1'b0;
                end
                ST_D_ST: begin
                    r_state <= ST_D_GAP;
                    r_cnt   <= GAP_LAST;
                    r_wr_n  <= 1'b1;
                    r_cs_n  <= CS_OFF;
                end
                ST_D_GAP: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_cnt   <= '0;
                    r_cs_n  <= CS_OFF;
                    r_wr_n  <= 1'b1;
                    r_rd_n  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ika2151_bus_writer.sv
// Randomised self-checking bench: a bus monitor turns strobes into transactions that are compared
// against transactions predicted from each accepted request and the documented cycle timing.
`timescale 1ns/1ps
module tb_ika2151_bus_writer;

    localparam int NCH   = 5;
    localparam int CW    = 3;
    localparam int SU    = 15;
    localparam int STB   = 20;
    localparam int GP    = 15;
    localparam int DEPTH = 16;
    localparam int PER   = 2 * (SU + STB + GP) + 1;

    typedef struct {
        int         chip;
        int         nlow;
        logic       a0;
        logic [7:0] d;
        int         su;
        int         st;
        int         cyc;
    } txn_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic           valid = 1'b0;
    logic [CW-1:0]  chip = '0;
    logic [7:0]     addr = 8'h00;
    logic [7:0]     data = 8'h00;
    logic           ready;
    logic [NCH-1:0] cs_n;
    logic           wr_n, rd_n, a0, idle;
    logic [7:0]     dout;
    logic [7:0]     din = 8'hFF;
    logic [4:0]     level;

    logic       p_valid = 1'b0;
    logic [0:0] p_chip = 1'b0;
    logic [7:0] p_addr = 8'h00;
    logic [7:0] p_data = 8'h00;
    logic       p_ready, p_wr_n, p_rd_n, p_a0, p_idle;
    logic [0:0] p_cs_n;
    logic [7:0] p_dout, p_din;
    logic [2:0] p_level;

    int pass_cnt = 0;
    int total_cnt = 0;

    txn_t obs_q[$];
    txn_t exp_q[$];
    int   cyc = 0;
    int   wr_falls = 0;
    int   rd_falls = 0;
    int   p_rd_falls = 0;
    int   p_wr_falls = 0;
    int   p_rd_at_wr = -1;
    logic [8:0] p_wr_seen [2];

    ika2151_bus_writer #(.FIFO_DEPTH(DEPTH), .NUM_CHIPS(NCH), .SETUP_CYC(SU), .STROBE_CYC(STB),
                         .GAP_CYC(GP), .BUSY_POLL(0)) dut (
        .i_EMUCLK(clk), .i_RST(rst), .i_REQ_VALID(valid), .o_REQ_READY(ready),
        .i_REQ_CHIP(chip), .i_REQ_ADDR(addr), .i_REQ_DATA(data), .o_CS_n(cs_n),
        .o_WR_n(wr_n), .o_RD_n(rd_n), .o_A0(a0), .o_D(dout), .i_D(din),
        .o_IDLE(idle), .o_LEVEL(level));

    ika2151_bus_writer #(.FIFO_DEPTH(4), .NUM_CHIPS(1), .SETUP_CYC(2), .STROBE_CYC(3),
                         .GAP_CYC(2), .BUSY_POLL(1)) dut_p (
        .i_EMUCLK(clk), .i_RST(rst), .i_REQ_VALID(p_valid), .o_REQ_READY(p_ready),
        .i_REQ_CHIP(p_chip), .i_REQ_ADDR(p_addr), .i_REQ_DATA(p_data), .o_CS_n(p_cs_n),
        .o_WR_n(p_wr_n), .o_RD_n(p_rd_n), .o_A0(p_a0), .o_D(p_dout), .i_D(p_din),
        .o_IDLE(p_idle), .o_LEVEL(p_level));

    // BUSY reads as set during the first three polls, clear from the fourth on
    assign p_din = (p_rd_falls <= 3) ? 8'h80 : 8'h00;

    function automatic int low_idx(input logic [NCH-1:0] v);
        for (int i = 0; i < NCH; i++) if (!v[i]) return i;
        return NCH;
    endfunction

    function automatic int low_cnt(input logic [NCH-1:0] v);
        int n = 0;
        for (int i = 0; i < NCH; i++) if (!v[i]) n++;
        return n;
    endfunction

    function automatic txn_t mk_exp(input int c, input logic ph, input logic [7:0] d);
        txn_t t;
        t.chip = (c < NCH) ? c : NCH;
        t.nlow = (c < NCH) ? 1 : 0;
        t.a0   = ph;
        t.d    = d;
        t.su   = (c < NCH) ? SU : 0;
        t.st   = STB;
        t.cyc  = 0;
        return t;
    endfunction

    function automatic logic [56:0] pack(input txn_t t);
        return {8'(t.chip), 8'(t.nlow), t.a0, t.d, 16'(t.su), 16'(t.st)};
    endfunction

    initial begin : mon_main
        int su_cnt, st_cnt;
        logic prev_wr, prev_rd;
        txn_t cur;
        su_cnt = 0; st_cnt = 0; prev_wr = 1'b1; prev_rd = 1'b1;
        cur = mk_exp(0, 1'b0, 8'h00);
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                su_cnt = 0; st_cnt = 0; prev_wr = 1'b1; prev_rd = 1'b1;
            end else begin
                if (!wr_n && prev_wr) begin
                    cur.chip = low_idx(cs_n); cur.nlow = low_cnt(cs_n);
                    cur.a0 = a0; cur.d = dout; cur.su = su_cnt; cur.cyc = cyc;
                    wr_falls++; st_cnt = 0;
                end
                if (!wr_n) st_cnt++;
                else if (!prev_wr) begin
                    cur.st = st_cnt;
                    obs_q.push_back(cur);
                end
                if ((cs_n != {NCH{1'b1}}) && wr_n) su_cnt++;
                else su_cnt = 0;
                if (!rd_n && prev_rd) rd_falls++;
                prev_wr = wr_n; prev_rd = rd_n;
            end
        end
    end

    initial begin : mon_poll
        logic prev_wr, prev_rd;
        prev_wr = 1'b1; prev_rd = 1'b1;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (!p_rd_n && prev_rd) p_rd_falls++;
                if (!p_wr_n && prev_wr) begin
                    if (p_wr_falls == 0) p_rd_at_wr = p_rd_falls;
                    if (p_wr_falls < 2) p_wr_seen[p_wr_falls] = {p_a0, p_dout};
                    p_wr_falls++;
                end
            end
            prev_wr = p_wr_n; prev_rd = p_rd_n;
        end
    end

    task automatic push(input logic [CW-1:0] c, input logic [7:0] a, input logic [7:0] d,
                        output logic acc);
        chip = c; addr = a; data = d; valid = 1'b1;
        acc = ready;
        @(posedge clk); #1;
        valid = 1'b0;
        if (acc) begin
            exp_q.push_back(mk_exp(int'(c), 1'b0, a));
            exp_q.push_back(mk_exp(int'(c), 1'b1, d));
        end
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n = 0;
        while (!idle && n < budget) begin @(posedge clk); #1; n++; end
        total_cnt++;
        if (idle !== 1'b1) $display("FAIL %s: idle=%b after %0d cycles, required 1", name, idle, n);
        else pass_cnt++;
    endtask

    task automatic check_txns(input string name);
        total_cnt++;
        if (obs_q.size() != exp_q.size())
            $display("FAIL %s count: got %0d bus writes, required %0d", name, obs_q.size(), exp_q.size());
        else pass_cnt++;
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            txn_t o, e;
            o = obs_q.pop_front(); e = exp_q.pop_front();
            total_cnt++;
            if (pack(o) !== pack(e))
                $display("FAIL %s txn {chip,nlow,a0,d,su,st}: got %0d,%0d,%b,%h,%0d,%0d required %0d,%0d,%b,%h,%0d,%0d",
                         name, o.chip, o.nlow, o.a0, o.d, o.su, o.st, e.chip, e.nlow, e.a0, e.d, e.su, e.st);
            else pass_cnt++;
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_reset();
        logic [22:0] exp_v;
        exp_v = {5'h1F, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 5'd0};
        repeat (3) @(posedge clk); #1;
        total_cnt++;
        if ({cs_n, wr_n, rd_n, a0, dout, ready, idle, level} !== exp_v)
            $display("FAIL reset_main: got %h required %h", {cs_n, wr_n, rd_n, a0, dout, ready, idle, level}, exp_v);
        else pass_cnt++;
        total_cnt++;
        if ({p_cs_n, p_wr_n, p_rd_n, p_a0, p_dout, p_ready, p_idle, p_level} !== {1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 3'd0})
            $display("FAIL reset_poll: got %h", {p_cs_n, p_wr_n, p_rd_n, p_a0, p_dout, p_ready, p_idle, p_level});
        else pass_cnt++;
        @(negedge clk); rst = 1'b0;
        repeat (3) @(posedge clk); #1;
        total_cnt++;
        if ({cs_n, wr_n, rd_n, a0, dout, ready, idle, level} !== exp_v)
            $display("FAIL post_reset_idle: got %h required %h", {cs_n, wr_n, rd_n, a0, dout, ready, idle, level}, exp_v);
        else pass_cnt++;
    endtask

    task automatic test_single_write();
        logic acc;
        logic [15:0] got, want;
        push(3'd0, 8'h18, 8'hFF, acc);
        total_cnt++;
        if ({acc, level, idle, cs_n} !== {1'b1, 5'd1, 1'b0, 5'h1F})
            $display("FAIL single_queued: got acc/level/idle/cs %b/%0d/%b/%h", acc, level, idle, cs_n);
        else pass_cnt++;
        for (int t = 1; t <= PER; t++) begin
            int p, ph;
            logic cs_low, wr_low;
            @(posedge clk); #1;
            p = t - 1;
            ph = p % (SU + STB + GP);
            cs_low = (p < PER - 1) && (ph < SU + STB);
            wr_low = (p < PER - 1) && (ph >= SU) && (ph < SU + STB);
            want = {cs_low ? 5'h1E : 5'h1F, ~wr_low, (p >= SU + STB + GP),
                    (p >= SU + STB + GP) ? 8'hFF : 8'h18, (p >= PER - 1)};
            got = {cs_n, wr_n, a0, dout, idle};
            total_cnt++;
            if (got !== want) $display("FAIL single_cycle%0d {cs,wr,a0,d,idle}: got %h required %h", t, got, want);
            else pass_cnt++;
        end
        check_txns("single");
    endtask

    task automatic test_back_to_back();
        int start_rd;
        start_rd = rd_falls;
        for (int i = 0; i < DEPTH + 2; i++) begin
            logic acc, want;
            push(CW'($urandom_range(0, NCH - 1)), 8'($urandom), 8'($urandom), acc);
            // the first entry leaves the queue one cycle after it lands, so DEPTH+1 fit
            want = (i < DEPTH + 1);
            total_cnt++;
            if (acc !== want) $display("FAIL b2b_accept%0d: got %b required %b", i, acc, want);
            else pass_cnt++;
        end
        total_cnt++;
        if ({ready, level} !== {1'b0, 5'd16}) $display("FAIL b2b_full: ready/level %b/%0d required 0/16", ready, level);
        else pass_cnt++;
        wait_idle("b2b_drain", (DEPTH + 1) * PER + 50);
        for (int k = 0; k + 2 < obs_q.size(); k += 2) begin
            total_cnt++;
            if (obs_q[k + 2].cyc - obs_q[k].cyc != PER)
                $display("FAIL b2b_period%0d: got %0d cycles required %0d", k / 2, obs_q[k + 2].cyc - obs_q[k].cyc, PER);
            else pass_cnt++;
        end
        check_txns("b2b");
        total_cnt++;
        if (rd_falls != start_rd) $display("FAIL no_poll_rd: got %0d RD strobes required 0", rd_falls - start_rd);
        else pass_cnt++;
    endtask

    task automatic test_chip_select();
        logic acc;
        push(3'd3, 8'($urandom), 8'($urandom), acc);
        push(3'd0, 8'($urandom), 8'($urandom), acc);
        push(3'd2, 8'($urandom), 8'($urandom), acc);
        wait_idle("chips_drain", 4 * PER);
        check_txns("chips");
        push(3'd5, 8'($urandom), 8'($urandom), acc);
        total_cnt++;
        if (level !== 5'd1) $display("FAIL bad_chip_queued: level %0d required 1", level);
        else pass_cnt++;
        @(posedge clk); #1;
        total_cnt++;
        if (level !== 5'd0) $display("FAIL bad_chip_consumed: level %0d required 0", level);
        else pass_cnt++;
        wait_idle("bad_chip_drain", 2 * PER);
        check_txns("bad_chip");
    endtask

    task automatic test_reset_mid();
        logic acc;
        int base, n, snap;
        base = wr_falls;
        push(3'd1, 8'($urandom), 8'($urandom), acc);
        push(3'd4, 8'($urandom), 8'($urandom), acc);
        n = 0;
        while (wr_falls < base + 2 && n < 2 * PER) begin @(posedge clk); #1; n++; end
        total_cnt++;
        if (wr_falls < base + 2) $display("FAIL mid_reach_dst: got %0d strobes required 2", wr_falls - base);
        else pass_cnt++;
        repeat (5) @(posedge clk);
        @(negedge clk); #2;
        rst = 1'b1;
        #1;
        total_cnt++;
        if ({cs_n, wr_n, level} !== {5'h1F, 1'b1, 5'd0})
            $display("FAIL mid_reset_async: cs/wr/level %h/%b/%0d required 1f/1/0", cs_n, wr_n, level);
        else pass_cnt++;
        @(posedge clk); @(negedge clk);
        rst = 1'b0;
        snap = wr_falls;
        repeat (2 * PER) @(posedge clk); #1;
        total_cnt++;
        if ((wr_falls != snap) || (idle !== 1'b1))
            $display("FAIL mid_no_more_strobes: got %0d strobes idle=%b required 0/1", wr_falls - snap, idle);
        else pass_cnt++;
        obs_q.delete(); exp_q.delete();
        push(3'd2, 8'($urandom), 8'($urandom), acc);
        wait_idle("after_reset_drain", 2 * PER);
        check_txns("after_reset");
    endtask

    task automatic test_busy_poll();
        logic [7:0] a, d;
        int n;
        a = 8'($urandom); d = 8'($urandom);
        p_addr = a; p_data = d; p_chip = 1'b0; p_valid = 1'b1;
        @(posedge clk); #1;
        p_valid = 1'b0;
        n = 0;
        while (!(p_idle && p_wr_falls >= 2) && n < 400) begin @(posedge clk); #1; n++; end
        total_cnt++;
        if (p_rd_falls != 4) $display("FAIL poll_rd_count: got %0d required 4", p_rd_falls);
        else pass_cnt++;
        total_cnt++;
        if (p_wr_falls != 2) $display("FAIL poll_wr_count: got %0d required 2", p_wr_falls);
        else pass_cnt++;
        total_cnt++;
        if (p_rd_at_wr != 4) $display("FAIL poll_wr_before_ready: RD count at first WR %0d required 4", p_rd_at_wr);
        else pass_cnt++;
        total_cnt++;
        if ({p_wr_seen[0], p_wr_seen[1]} !== {1'b0, a, 1'b1, d})
            $display("FAIL poll_write_data: got %h %h required %h %h", p_wr_seen[0], p_wr_seen[1], {1'b0, a}, {1'b1, d});
        else pass_cnt++;
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin : main
        test_reset();
        test_single_write();
        test_back_to_back();
        test_chip_select();
        test_reset_mid();
        test_busy_poll();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
